// File: rtl/ahb_si_slave_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_si_slave_arbiter
//
// Per-slave arbiter of the AHB_Gen interconnect. It turns decoded master
// requests into one-hot selects for the interconnect muxes:
//   grant_addr : address-phase owner, selects the master->slave request mux
//   grant_data : data-phase owner, selects the slave->master response mux
// Arbitration is round-robin. A burst in progress (owner presenting SEQ/BUSY)
// is never broken.
//
// Optional build macro:
//   AHB_SI_LOCK_EN : honour HMASTLOCK. A locked owner keeps the slave across
//                    NONSEQ/IDLE transfers, and the round-robin pointer does
//                    not move while the lock is held. Without the macro,
//                    hmastlock is accepted but ignored.
//
// Parameters:
//   MASTER_NUM   number of masters competing for this slave (one-hot width)
//
// Ports:
//   HCLK         interconnect clock, rising edge
//   HRESETn      asynchronous active-low reset
//   req          per-master request (decoder hit with HTRANS != IDLE)
//   htrans       per-master HTRANS, 2 bits per master
//   hready_slv   HREADYOUT of this slave
//   hmastlock    per-master HMASTLOCK (used only with AHB_SI_LOCK_EN)
//   grant_addr   one-hot/zero address-phase owner
//   grant_data   one-hot/zero data-phase owner
//   master_wait  bit i set: master i is stalled (its HREADY forced low)
// ----------------------------------------------------------------------------
module ahb_si_slave_arbiter #(
  parameter int MASTER_NUM = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [MASTER_NUM-1:0]   req,
  input  logic [2*MASTER_NUM-1:0] htrans,
  input  logic                    hready_slv,
  input  logic [MASTER_NUM-1:0]   hmastlock,
  output logic [MASTER_NUM-1:0]   grant_addr,
  output logic [MASTER_NUM-1:0]   grant_data,
  output logic [MASTER_NUM-1:0]   master_wait
);

  localparam int PTR_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    S_IDLE,
    S_OWN
  } state_e;

  state_e           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner_idx;   // binary copy of grant_addr, valid in S_OWN

  logic [1:0]       owner_htrans;
  logic             owner_req;
  logic             burst_hold;
  logic             lock_hold;
  logic             arb_point;
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] win_next;

  // --------------------------------------------------------------------------
  // Owner status
  // --------------------------------------------------------------------------
  always_comb begin
    owner_htrans = htrans[int'(owner_idx)*2 +: 2];
    owner_req    = req[owner_idx];
    // Owner still mid-burst: keep the grant no matter who else is asking.
    burst_hold   = (state == S_OWN) && owner_req &&
                   ((owner_htrans == HT_SEQ) || (owner_htrans == HT_BUSY));
  end

`ifdef AHB_SI_LOCK_EN
  // A locked owner is not re-arbitrated, even when it drops req or goes
  // NONSEQ/IDLE; it is released on the first accepted cycle without lock.
  always_comb lock_hold = (state == S_OWN) && hmastlock[owner_idx];
`else
  logic unused_hmastlock;
  assign unused_hmastlock = ^hmastlock;
  always_comb lock_hold = 1'b0;
`endif

  always_comb arb_point = hready_slv && !burst_hold && !lock_hold;

  // --------------------------------------------------------------------------
  // Round-robin search starting at rr_ptr. rr_ptr always sits one past the
  // last winner, so the current owner is naturally the last candidate.
  // --------------------------------------------------------------------------
  // NOTE: combinational blocks assign every output a default first and use
  // blocking '=', so no latch is inferred and the loop sees its own updates.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      if (!win_found && req[(int'(rr_ptr) + k) % MASTER_NUM]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(rr_ptr) + k) % MASTER_NUM);
      end
    end
    win_next = PTR_W'((int'(win_idx) + 1) % MASTER_NUM);
  end

  // --------------------------------------------------------------------------
  // Grant registers. Everything freezes while the slave stalls.
  // --------------------------------------------------------------------------
  // NOTE: state is written with non-blocking '<=' so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      grant_addr <= '0;
      grant_data <= '0;
      rr_ptr     <= '0;
      owner_idx  <= '0;
    end else if (hready_slv) begin
      // The accepted address phase moves into its data phase.
      grant_data <= grant_addr;
      if (arb_point) begin
        if (win_found) begin
          state      <= S_OWN;
          grant_addr <= MASTER_NUM'(1) << win_idx;
          owner_idx  <= win_idx;
          rr_ptr     <= win_next;
        end else begin
          state      <= S_IDLE;
          grant_addr <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stall: losers wait for a grant; owners of either phase wait on the slave.
  // --------------------------------------------------------------------------
  always_comb begin
    master_wait = (req & ~grant_addr)
                | (grant_addr & {MASTER_NUM{~hready_slv}})
                | (grant_data & {MASTER_NUM{~hready_slv}});
  end

  a_grant_onehot: assert property (
    @(posedge HCLK) disable iff (!HRESETn)
      $onehot0(grant_addr) && $onehot0(grant_data)
  );

endmodule

// File: tb/tb_ahb_si_slave_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_si_slave_arbiter
//
// Self-checking bench for ahb_si_slave_arbiter (MASTER_NUM = 4). A reference
// model tracks the owner, data-phase owner and round-robin pointer as plain
// integers and derives the expected selects and stalls from the arbitration
// rules. Directed openers cover reset, first-grant latency and the
// round-robin wrap; the rest is randomized burst traffic with slave stalls,
// lock requests and an asynchronous reset in mid-traffic.
// ----------------------------------------------------------------------------
module tb_ahb_si_slave_arbiter;

  localparam int N = 4;
`ifdef AHB_SI_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic [N-1:0]   req;
  logic [2*N-1:0] htrans;
  logic           hready_slv;
  logic [N-1:0]   hmastlock;
  logic [N-1:0]   grant_addr;
  logic [N-1:0]   grant_data;
  logic [N-1:0]   master_wait;

  ahb_si_slave_arbiter #(.MASTER_NUM(N)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .req         (req),
    .htrans      (htrans),
    .hready_slv  (hready_slv),
    .hmastlock   (hmastlock),
    .grant_addr  (grant_addr),
    .grant_data  (grant_data),
    .master_wait (master_wait)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: -1 means "nobody".
  // --------------------------------------------------------------------------
  int m_owner = -1;
  int m_data  = -1;
  int m_rr    = 0;

  function automatic logic [N-1:0] onehot(input int idx);
    return (idx < 0) ? '0 : N'(1 << idx);
  endfunction

  function automatic logic [N-1:0] exp_wait(input logic [N-1:0] r, input logic h);
    logic [N-1:0] w;
    for (int i = 0; i < N; i++)
      w[i] = (r[i] && m_owner != i) || (!h && (m_owner == i || m_data == i));
    return w;
  endfunction

  // Apply one rising edge to the model.
  task automatic model_edge(input logic [N-1:0] r, input logic [2*N-1:0] t,
                            input logic h, input logic [N-1:0] l);
    logic [1:0] ot;
    bit         held;
    int         w;
    if (!h) return;
    m_data = m_owner;
    held = 1'b0;
    if (m_owner >= 0) begin
      ot   = t[2*m_owner +: 2];
      held = (r[m_owner] && (ot == T_SEQ || ot == T_BUSY)) || (LOCK_EN && l[m_owner]);
    end
    if (!held) begin
      // Other requesters in rr order first, then the current owner.
      w = -1;
      for (int k = 0; k < N; k++) begin
        int m;
        m = (m_rr + k) % N;
        if (w < 0 && r[m] && m != m_owner) w = m;
      end
      if (w < 0 && m_owner >= 0 && r[m_owner]) w = m_owner;
      m_owner = w;
      if (w >= 0) m_rr = (w + 1) % N;
    end
  endtask

  // One clock: drive after the falling edge, check stalls, then check grants
  // just after the rising edge.
  task automatic cycle(input logic [N-1:0] r, input logic [2*N-1:0] t,
                       input logic h, input logic [N-1:0] l);
    @(negedge HCLK);
    HRESETn    = 1'b1;
    req        = r;
    htrans     = t;
    hready_slv = h;
    hmastlock  = l;
    #1;
    check("master_wait", master_wait, exp_wait(r, h));
    @(posedge HCLK);
    model_edge(r, t, h, l);
    #1;
    check("grant_addr", grant_addr, onehot(m_owner));
    check("grant_data", grant_data, onehot(m_data));
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic async_reset();
    @(negedge HCLK);
    req = 4'b1111;
    #2 HRESETn = 1'b0;
    #1;
    check("rst_grant_addr", grant_addr, '0);
    check("rst_grant_data", grant_data, '0);
    check("rst_master_wait", master_wait, 4'b1111);
    m_owner = -1;
    m_data  = -1;
    m_rr    = 0;
  endtask

  // --------------------------------------------------------------------------
  // Random burst traffic generator
  // --------------------------------------------------------------------------
  bit act  [N];
  int beat [N];
  int blen [N];

  task automatic gen(output logic [N-1:0] r, output logic [2*N-1:0] t,
                     output logic h, output logic [N-1:0] l);
    logic [1:0] ht;
    for (int i = 0; i < N; i++) begin
      if (!act[i] && $urandom_range(0, 3) == 0) begin
        act[i]  = 1'b1;
        beat[i] = 0;
        blen[i] = $urandom_range(1, 4);
      end
      if (act[i]) begin
        ht   = (beat[i] == 0) ? T_NONSEQ : (($urandom_range(0, 7) == 0) ? T_BUSY : T_SEQ);
        r[i] = ($urandom_range(0, 15) != 0);
      end else begin
        ht   = T_IDLE;
        r[i] = 1'b0;
      end
      t[2*i +: 2] = ht;
      l[i] = ($urandom_range(0, 3) == 0);
    end
    h = ($urandom_range(0, 4) != 0);
  endtask

  // A beat completes when its master owned the address phase at an accepted edge.
  task automatic advance(input int owner, input logic [N-1:0] r,
                         input logic [2*N-1:0] t, input logic h);
    for (int i = 0; i < N; i++) begin
      if (act[i] && owner == i && h && r[i] && t[2*i +: 2] != T_BUSY) begin
        beat[i]++;
        if (beat[i] >= blen[i]) act[i] = 1'b0;
      end
    end
  endtask

  initial begin
    logic [N-1:0]   r;
    logic [2*N-1:0] t;
    logic           h;
    logic [N-1:0]   l;
    int             pre_owner;

    HRESETn    = 1'b0;
    req        = 4'b1111;
    htrans     = {4{T_NONSEQ}};
    hready_slv = 1'b1;
    hmastlock  = '0;
    for (int i = 0; i < N; i++) act[i] = 1'b0;

    // Reset state with all masters requesting.
    #12;
    check("reset_grant_addr", grant_addr, '0);
    check("reset_grant_data", grant_data, '0);
    check("reset_master_wait", master_wait, 4'b1111);

    // First grant one edge after release, data-phase copy one edge later.
    cycle(4'b1111, {4{T_NONSEQ}}, 1'b1, '0);
    check("first_grant", grant_addr, 4'b0001);
    cycle(4'b1111, {4{T_NONSEQ}}, 1'b1, '0);
    check("first_data", grant_data, 4'b0001);

    // Round-robin wrap: master 2 wins (rr -> 3), then 3 beats 0, then 0 wins.
    cycle(4'b0100, {T_IDLE, T_NONSEQ, T_IDLE, T_IDLE}, 1'b1, '0);
    check("wrap_m2", grant_addr, 4'b0100);
    cycle(4'b1001, {T_NONSEQ, T_IDLE, T_IDLE, T_NONSEQ}, 1'b1, '0);
    check("wrap_m3", grant_addr, 4'b1000);
    cycle(4'b1001, {T_NONSEQ, T_IDLE, T_IDLE, T_NONSEQ}, 1'b1, '0);
    check("wrap_m0", grant_addr, 4'b0001);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        async_reset();
        for (int i = 0; i < N; i++) act[i] = 1'b0;
      end
      gen(r, t, h, l);
      pre_owner = m_owner;
      cycle(r, t, h, l);
      advance(pre_owner, r, t, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
